// File: rtl/elevator_shaft_if.sv
// Controller-to-shaft bundle: motor/door commands toward the car, sensors and
// status back toward the controller.
interface elevator_shaft_if;
  logic [1:0] AC;
  logic       Open;
  logic       S1;
  logic       S2;
  logic       S3;
  logic       S4;
  logic       S5;
  logic [2:0] floor;
  logic       moving;
  logic       fault;

  modport master (
    output AC, Open,
    input  S1, S2, S3, S4, S5, floor, moving, fault
  );

  modport slave (
    input  AC, Open,
    output S1, S2, S3, S4, S5, floor, moving, fault
  );
endinterface

// File: rtl/elevator_shaft.sv
// Cycle-accurate car/shaft model: integrates motor commands into a position
// counter over five floors and drives the per-floor sensors back to the controller.
module elevator_shaft #(
  parameter int unsigned TRAVEL_CYCLES = 8,
  parameter int unsigned SENSE_CYCLES  = 3
) (
  input  logic              clk,
  input  logic              rst,
  elevator_shaft_if.slave   bus
);
  localparam int unsigned PW = $clog2(4 * TRAVEL_CYCLES + 1);
  localparam int unsigned CW = $clog2(SENSE_CYCLES + 1);

  typedef enum logic [1:0] {ALIGNED, MOVE, DWELL, FAULT} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   p, p_n;
  logic            dir, dir_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      floor_n;
  logic [4:0]      sense_n;
  logic            step_dir;
  logic            fault_det;

  always_comb begin
    state_n  = state;
    p_n      = p;
    dir_n    = dir;
    cnt_n    = cnt;
    floor_n  = bus.floor;
    step_dir = dir;

    fault_det = (bus.AC == 2'b11)
             || (state == MOVE    && bus.Open)
             || (state == ALIGNED && bus.AC == 2'b01 && bus.floor == 3'd5)
             || (state == ALIGNED && bus.AC == 2'b10 && bus.floor == 3'd1);

    case (state)
      ALIGNED: begin
        if (fault_det) begin
          state_n = FAULT;
        end else if (bus.AC == 2'b01) begin
          dir_n   = 1'b1;
          p_n     = p + 1'b1;
          state_n = MOVE;
        end else if (bus.AC == 2'b10) begin
          dir_n   = 1'b0;
          p_n     = p - 1'b1;
          state_n = MOVE;
        end
      end
      MOVE: begin
        if (fault_det) begin
          state_n = FAULT;
        end else begin
          // A fresh command overrides dir before this step; 00 coasts on.
          if (bus.AC == 2'b01)      step_dir = 1'b1;
          else if (bus.AC == 2'b10) step_dir = 1'b0;
          dir_n = step_dir;
          p_n   = step_dir ? p + 1'b1 : p - 1'b1;
          for (int unsigned k = 0; k < 5; k++) begin
            if (p_n == PW'(k * TRAVEL_CYCLES)) begin
              floor_n = 3'(k + 1);
              cnt_n   = CW'(SENSE_CYCLES);
              state_n = DWELL;
            end
          end
        end
      end
      DWELL: begin
        if (fault_det) begin
          state_n = FAULT;
        end else begin
          cnt_n = cnt - 1'b1;
          if (cnt == CW'(1)) state_n = ALIGNED;
        end
      end
      default: ;
    endcase

    sense_n = '0;
    for (int unsigned k = 0; k < 5; k++) begin
      sense_n[k] = (p_n == PW'(k * TRAVEL_CYCLES)) && (state_n != MOVE);
    end
  end

  // Outputs are registered from the next-state values so they line up with state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ALIGNED;
      p          <= '0;
      dir        <= 1'b1;
      cnt        <= '0;
      bus.floor  <= 3'd1;
      bus.S1     <= 1'b1;
      bus.S2     <= 1'b0;
      bus.S3     <= 1'b0;
      bus.S4     <= 1'b0;
      bus.S5     <= 1'b0;
      bus.moving <= 1'b0;
      bus.fault  <= 1'b0;
    end else begin
      state      <= state_n;
      p          <= p_n;
      dir        <= dir_n;
      cnt        <= cnt_n;
      bus.floor  <= floor_n;
      bus.S1     <= sense_n[0];
      bus.S2     <= sense_n[1];
      bus.S3     <= sense_n[2];
      bus.S4     <= sense_n[3];
      bus.S5     <= sense_n[4];
      bus.moving <= (state_n == MOVE);
      bus.fault  <= (state_n == FAULT);
    end
  end
endmodule

// File: tb/tb_elevator_shaft.sv
// Scoreboard bench for elevator_shaft: directed command sequences queue their
// expected sensor/status snapshots by cycle; a monitor compares on each negedge.
module tb_elevator_shaft;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  elevator_shaft_if bus ();

  elevator_shaft #(.TRAVEL_CYCLES(8), .SENSE_CYCLES(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  typedef struct {
    string      name;
    int         cyc;
    logic [4:0] s;      // {S5,S4,S3,S2,S1}
    logic [2:0] fl;
    logic       mv;
    logic       flt;
    int         p;      // -1: position not checked
  } exp_t;

  exp_t q[$];

  task automatic expect_at(input string name, input int c, input logic [4:0] s,
                           input logic [2:0] fl, input logic mv, input logic flt,
                           input int p);
    exp_t e;
    e.name = name; e.cyc = c; e.s = s; e.fl = fl; e.mv = mv; e.flt = flt; e.p = p;
    q.push_back(e);
  endtask

  // Monitor: pops every expectation due this cycle.
  always @(negedge clk) begin
    logic [4:0] s_act;
    s_act = {bus.S5, bus.S4, bus.S3, bus.S2, bus.S1};
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d missed (now cycle %0d)", e.name, e.cyc, cyc);
      end else if (s_act !== e.s || bus.floor !== e.fl || bus.moving !== e.mv ||
                   bus.fault !== e.flt || (e.p >= 0 && int'(dut.p) != e.p)) begin
        errors++;
        $display("FAIL %s @%0d: got S=%b floor=%0d moving=%b fault=%b p=%0d, want S=%b floor=%0d moving=%b fault=%b p=%0d",
                 e.name, cyc, s_act, bus.floor, bus.moving, bus.fault, dut.p,
                 e.s, e.fl, e.mv, e.flt, e.p);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycle(input int n);
    int guard = 0;
    while (cyc != n && guard < 500) begin
      next_cycle();
      guard++;
    end
    if (cyc != n) begin
      checks++;
      errors++;
      $display("FAIL wait_cycle: cycle %0d never reached (at %0d)", n, cyc);
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (q.size() > 0 && guard < 200) begin
      next_cycle();
      guard++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations never compared", q.size());
      q.delete();
    end
  endtask

  // Leaves the bench #1 into cycle 0 with reset released.
  task automatic do_reset();
    #1;
    rst = 1'b0;
    bus.AC = 2'b00;
    bus.Open = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
  endtask

  initial begin
    bus.AC = 2'b00;
    bus.Open = 1'b0;

    // Reset state
    do_reset();
    expect_at("reset", 0, 5'b00001, 3'd1, 1'b0, 1'b0, 0);
    next_cycle();
    next_cycle();
    drain();

    // Pass-through up to floor 5, then up-command at floor 5 faults
    do_reset();
    bus.AC = 2'b01;
    expect_at("pt_c0",   0,  5'b00001, 3'd1, 1'b0, 1'b0, 0);
    expect_at("pt_dep",  1,  5'b00000, 3'd1, 1'b1, 1'b0, 1);
    expect_at("pt_c7",   7,  5'b00000, 3'd1, 1'b1, 1'b0, 7);
    expect_at("pt_s2a",  8,  5'b00010, 3'd2, 1'b0, 1'b0, 8);
    expect_at("pt_s2b",  11, 5'b00010, 3'd2, 1'b0, 1'b0, 8);
    expect_at("pt_dep2", 12, 5'b00000, 3'd2, 1'b1, 1'b0, 9);
    expect_at("pt_c18",  18, 5'b00000, 3'd2, 1'b1, 1'b0, 15);
    expect_at("pt_s3a",  19, 5'b00100, 3'd3, 1'b0, 1'b0, 16);
    expect_at("pt_s3b",  22, 5'b00100, 3'd3, 1'b0, 1'b0, 16);
    expect_at("pt_dep3", 23, 5'b00000, 3'd3, 1'b1, 1'b0, 17);
    expect_at("pt_s4",   30, 5'b01000, 3'd4, 1'b0, 1'b0, 24);
    expect_at("pt_s5",   41, 5'b10000, 3'd5, 1'b0, 1'b0, 32);
    expect_at("pt_s5al", 44, 5'b10000, 3'd5, 1'b0, 1'b0, 32);
    expect_at("pt_top",  45, 5'b10000, 3'd5, 1'b0, 1'b1, 32);
    wait_cycle(46);
    drain();

    // Stop at floor 2 once its sensor is seen
    do_reset();
    bus.AC = 2'b01;
    expect_at("stop_s2",   8,  5'b00010, 3'd2, 1'b0, 1'b0, 8);
    expect_at("stop_al",   11, 5'b00010, 3'd2, 1'b0, 1'b0, 8);
    expect_at("stop_hold", 20, 5'b00010, 3'd2, 1'b0, 1'b0, 8);
    begin
      int guard = 0;
      while (!bus.S2 && guard < 30) begin
        next_cycle();
        guard++;
      end
    end
    bus.AC = 2'b00;
    wait_cycle(21);
    drain();

    // Reversal from floor 3
    do_reset();
    bus.AC = 2'b01;
    wait_cycle(19);
    bus.AC = 2'b00;
    expect_at("rev_f3",   22, 5'b00100, 3'd3, 1'b0, 1'b0, 16);
    expect_at("rev_up3",  28, 5'b00000, 3'd3, 1'b1, 1'b0, 19);
    expect_at("rev_back", 30, 5'b00000, 3'd3, 1'b1, 1'b0, 17);
    expect_at("rev_arr",  31, 5'b00100, 3'd3, 1'b0, 1'b0, 16);
    expect_at("rev_al",   34, 5'b00100, 3'd3, 1'b0, 1'b0, 16);
    expect_at("rev_dn",   35, 5'b00000, 3'd3, 1'b1, 1'b0, 15);
    wait_cycle(25);
    bus.AC = 2'b01;
    wait_cycle(28);
    bus.AC = 2'b10;
    wait_cycle(36);
    drain();

    // Door open while moving: fault, position frozen
    do_reset();
    bus.AC = 2'b01;
    expect_at("open_mv",   3,  5'b00000, 3'd1, 1'b1, 1'b0, 3);
    expect_at("open_flt",  4,  5'b00000, 3'd1, 1'b0, 1'b1, 3);
    expect_at("open_hold", 14, 5'b00000, 3'd1, 1'b0, 1'b1, 3);
    wait_cycle(3);
    bus.Open = 1'b1;
    next_cycle();
    bus.Open = 1'b0;
    wait_cycle(15);
    drain();

    // Down command at floor 1
    do_reset();
    bus.AC = 2'b10;
    expect_at("dn_f1",   1, 5'b00001, 3'd1, 1'b0, 1'b1, 0);
    expect_at("dn_f1_h", 5, 5'b00001, 3'd1, 1'b0, 1'b1, 0);
    next_cycle();
    bus.AC = 2'b00;
    wait_cycle(6);
    drain();

    // Illegal AC while aligned
    do_reset();
    bus.AC = 2'b11;
    expect_at("ill_al", 1, 5'b00001, 3'd1, 1'b0, 1'b1, 0);
    next_cycle();
    bus.AC = 2'b00;
    next_cycle();
    drain();

    // Illegal AC during dwell at floor 2
    do_reset();
    bus.AC = 2'b01;
    expect_at("ill_dw", 10, 5'b00010, 3'd2, 1'b0, 1'b1, 8);
    wait_cycle(9);
    bus.AC = 2'b11;
    next_cycle();
    bus.AC = 2'b00;
    next_cycle();
    drain();

    // Reset mid-move at p=13
    do_reset();
    bus.AC = 2'b01;
    expect_at("mid_p13", 16, 5'b00000, 3'd2, 1'b1, 1'b0, 13);
    wait_cycle(16);
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    bus.AC = 2'b00;
    expect_at("mid_rst", 0, 5'b00001, 3'd1, 1'b0, 1'b0, 0);
    next_cycle();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
